// File: rtl/pcie_pipe_pkg.sv
// Shared PIPE encodings and responder FSM states.
package pcie_pipe_pkg;

  // PowerDown encodings
  localparam logic [3:0] PD_P0  = 4'd0;
  localparam logic [3:0] PD_P0S = 4'd1;
  localparam logic [3:0] PD_P1  = 4'd2;
  localparam logic [3:0] PD_P2  = 4'd3;

  // RxStatus codes
  localparam logic [2:0] RXSTAT_OK       = 3'b000;
  localparam logic [2:0] RXSTAT_DETECTED = 3'b011;

  // Latency down-counter width
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    ST_RST_WAIT = 3'd0,
    ST_IDLE     = 3'd1,
    ST_DETECT   = 3'd2,
    ST_PD_CHG   = 3'd3,
    ST_RATE_CHG = 3'd4,
    ST_RESPOND  = 3'd5
  } phy_state_t;

endpackage

// File: rtl/pipe_phy_lane.sv
// One PIPE lane: registered Tx/Rx paths and the P0 loopback mux.
module pipe_phy_lane
  import pcie_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [3:0]          powerdown_i,
  input  logic                tx_det_lpbk_i,
  input  logic [DATA_W-1:0]   tx_data_i,
  input  logic [DATA_W/8-1:0] tx_datak_i,
  input  logic                tx_valid_i,
  input  logic                tx_elecidle_i,
  input  logic [DATA_W-1:0]   far_rx_data_i,
  input  logic [DATA_W/8-1:0] far_rx_datak_i,
  input  logic                far_rx_valid_i,
  input  logic                far_rx_elecidle_i,
  output logic [DATA_W-1:0]   rx_data_o,
  output logic [DATA_W/8-1:0] rx_datak_o,
  output logic                rx_data_valid_o,
  output logic                rx_valid_o,
  output logic                rx_elecidle_o,
  output logic [DATA_W-1:0]   far_tx_data_o,
  output logic [DATA_W/8-1:0] far_tx_datak_o,
  output logic                far_tx_valid_o,
  output logic                far_tx_elecidle_o
);

  localparam int unsigned K_W = DATA_W / 8;

  logic [DATA_W-1:0] rx_data_q, rx_data_d, ftx_data_q, ftx_data_d;
  logic [K_W-1:0]    rx_datak_q, rx_datak_d, ftx_datak_q, ftx_datak_d;
  logic              rx_dv_q, rx_dv_d, rx_valid_q, rx_valid_d;
  logic              rx_ei_q, rx_ei_d, rx_raw_valid_q, rx_raw_valid_d;
  logic              ftx_valid_q, ftx_valid_d, ftx_ei_q, ftx_ei_d;
  logic              is_p0;

  // Next-state for the Rx capture and the Tx/loopback mux
  always_comb begin
    is_p0          = (powerdown_i == PD_P0);
    rx_data_d      = far_rx_data_i;
    rx_datak_d     = far_rx_datak_i;
    rx_raw_valid_d = far_rx_valid_i;
    rx_dv_d        = far_rx_valid_i & is_p0;
    rx_valid_d     = far_rx_valid_i & is_p0 & ~far_rx_elecidle_i;
    rx_ei_d        = far_rx_elecidle_i;
    ftx_data_d     = '0;
    ftx_datak_d    = '0;
    ftx_valid_d    = 1'b0;
    ftx_ei_d       = 1'b1;
    if (is_p0) begin
      if (tx_det_lpbk_i) begin
        // Loopback retransmits what was captured from the partner
        ftx_data_d  = rx_data_q;
        ftx_datak_d = rx_datak_q;
        ftx_valid_d = rx_raw_valid_q;
        ftx_ei_d    = rx_ei_q;
      end else begin
        ftx_data_d  = tx_data_i;
        ftx_datak_d = tx_datak_i;
        ftx_valid_d = tx_valid_i;
        ftx_ei_d    = tx_elecidle_i;
      end
    end
  end

  // Lane registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data_q      <= '0;
      rx_datak_q     <= '0;
      rx_raw_valid_q <= 1'b0;
      rx_dv_q        <= 1'b0;
      rx_valid_q     <= 1'b0;
      rx_ei_q        <= 1'b1;
      ftx_data_q     <= '0;
      ftx_datak_q    <= '0;
      ftx_valid_q    <= 1'b0;
      ftx_ei_q       <= 1'b1;
    end else begin
      rx_data_q      <= rx_data_d;
      rx_datak_q     <= rx_datak_d;
      rx_raw_valid_q <= rx_raw_valid_d;
      rx_dv_q        <= rx_dv_d;
      rx_valid_q     <= rx_valid_d;
      rx_ei_q        <= rx_ei_d;
      ftx_data_q     <= ftx_data_d;
      ftx_datak_q    <= ftx_datak_d;
      ftx_valid_q    <= ftx_valid_d;
      ftx_ei_q       <= ftx_ei_d;
    end
  end

  assign rx_data_o         = rx_data_q;
  assign rx_datak_o        = rx_datak_q;
  assign rx_data_valid_o   = rx_dv_q;
  assign rx_valid_o        = rx_valid_q;
  assign rx_elecidle_o     = rx_ei_q;
  assign far_tx_data_o     = ftx_data_q;
  assign far_tx_datak_o    = ftx_datak_q;
  assign far_tx_valid_o    = ftx_valid_q;
  assign far_tx_elecidle_o = ftx_ei_q;

endmodule

// File: rtl/pipe_phy_responder.sv
// PHY-side PIPE responder: command FSM with PhyStatus/RxStatus plus per-lane data paths.
module pipe_phy_responder
  import pcie_pipe_pkg::*;
#(
  parameter int unsigned LANESNUMBER    = 16,
  parameter int unsigned MAXPIPEWIDTH   = 32,
  parameter int unsigned DETECT_LATENCY = 8,
  parameter int unsigned PD_LATENCY     = 4,
  parameter int unsigned RATE_LATENCY   = 16,
  parameter int unsigned RESET_LATENCY  = 4
) (
  input  logic                                    CLK,
  input  logic                                    reset,
  input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0]     TxData,
  input  logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] TxDataK,
  input  logic [LANESNUMBER-1:0]                  TxDataValid,
  input  logic [LANESNUMBER-1:0]                  TxElecIdle,
  input  logic [LANESNUMBER-1:0]                  TxDetectRx_Loopback,
  input  logic [4*LANESNUMBER-1:0]                PowerDown,
  input  logic [3:0]                              Rate,
  output logic [MAXPIPEWIDTH*LANESNUMBER-1:0]     RxData,
  output logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] RxDataK,
  output logic [LANESNUMBER-1:0]                  RxDataValid,
  output logic [LANESNUMBER-1:0]                  RxValid,
  output logic [3*LANESNUMBER-1:0]                RxStatus,
  output logic [LANESNUMBER-1:0]                  RxElectricalIdle,
  output logic [LANESNUMBER-1:0]                  PhyStatus,
  input  logic                                    far_present,
  input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0]     far_rx_data,
  input  logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] far_rx_datak,
  input  logic [LANESNUMBER-1:0]                  far_rx_valid,
  input  logic [LANESNUMBER-1:0]                  far_rx_elecidle,
  output logic [MAXPIPEWIDTH*LANESNUMBER-1:0]     far_tx_data,
  output logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] far_tx_datak,
  output logic [LANESNUMBER-1:0]                  far_tx_valid,
  output logic [LANESNUMBER-1:0]                  far_tx_elecidle
);

  localparam int unsigned W   = MAXPIPEWIDTH;
  localparam int unsigned K_W = MAXPIPEWIDTH / 8;

  phy_state_t                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [4*LANESNUMBER-1:0]   pd_prev_q, pd_prev_d;
  logic [3:0]                 rate_prev_q;
  logic                       det_prev_q;
  logic [LANESNUMBER-1:0]     phystatus_q, phystatus_d;
  logic [3*LANESNUMBER-1:0]   rxstatus_q, rxstatus_d;
  logic                       rate_chg, pd_chg, det_req;

  assign rate_chg = (Rate != rate_prev_q);
  assign pd_chg   = (PowerDown != pd_prev_q);
  assign det_req  = (PowerDown[3:0] == PD_P1) && TxDetectRx_Loopback[0] && !det_prev_q;

  // Command FSM next-state, latency counter and PhyStatus/RxStatus
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pd_prev_d   = pd_prev_q;
    phystatus_d = '0;
    rxstatus_d  = {LANESNUMBER{RXSTAT_OK}};
    case (state_q)
      ST_RST_WAIT: begin
        // Track PowerDown so the level held through reset is not seen as a change
        pd_prev_d = PowerDown;
        if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_IDLE: begin
        if (rate_chg) begin
          state_d = ST_RATE_CHG;
          cnt_d   = CNT_W'(RATE_LATENCY);
        end else if (pd_chg) begin
          state_d   = ST_PD_CHG;
          cnt_d     = CNT_W'(PD_LATENCY);
          pd_prev_d = PowerDown;
        end else if (det_req) begin
          state_d = ST_DETECT;
          cnt_d   = CNT_W'(DETECT_LATENCY);
        end
      end
      ST_DETECT, ST_PD_CHG, ST_RATE_CHG: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESPOND;
          if (state_q == ST_DETECT && far_present)
            rxstatus_d = {LANESNUMBER{RXSTAT_DETECTED}};
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_RST_WAIT;
    endcase
    if (state_d == ST_RST_WAIT || state_d == ST_RESPOND) phystatus_d = '1;
  end

  // FSM state, counter and command history registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RST_WAIT;
      cnt_q       <= CNT_W'(RESET_LATENCY);
      pd_prev_q   <= '0;
      rate_prev_q <= '0;
      det_prev_q  <= 1'b0;
      phystatus_q <= '1;
      rxstatus_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pd_prev_q   <= pd_prev_d;
      rate_prev_q <= Rate;
      det_prev_q  <= TxDetectRx_Loopback[0];
      phystatus_q <= phystatus_d;
      rxstatus_q  <= rxstatus_d;
    end
  end

  assign PhyStatus = phystatus_q;
  assign RxStatus  = rxstatus_q;

  // Per-lane data paths
  for (genvar g = 0; g < LANESNUMBER; g++) begin : g_lane
    pipe_phy_lane #(.DATA_W(W)) u_lane (
      .clk_i             (CLK),
      .rst_i             (reset),
      .powerdown_i       (PowerDown[4*g +: 4]),
      .tx_det_lpbk_i     (TxDetectRx_Loopback[g]),
      .tx_data_i         (TxData[W*g +: W]),
      .tx_datak_i        (TxDataK[K_W*g +: K_W]),
      .tx_valid_i        (TxDataValid[g]),
      .tx_elecidle_i     (TxElecIdle[g]),
      .far_rx_data_i     (far_rx_data[W*g +: W]),
      .far_rx_datak_i    (far_rx_datak[K_W*g +: K_W]),
      .far_rx_valid_i    (far_rx_valid[g]),
      .far_rx_elecidle_i (far_rx_elecidle[g]),
      .rx_data_o         (RxData[W*g +: W]),
      .rx_datak_o        (RxDataK[K_W*g +: K_W]),
      .rx_data_valid_o   (RxDataValid[g]),
      .rx_valid_o        (RxValid[g]),
      .rx_elecidle_o     (RxElectricalIdle[g]),
      .far_tx_data_o     (far_tx_data[W*g +: W]),
      .far_tx_datak_o    (far_tx_datak[K_W*g +: K_W]),
      .far_tx_valid_o    (far_tx_valid[g]),
      .far_tx_elecidle_o (far_tx_elecidle[g])
    );
  end

endmodule

// File: tb/tb_pipe_phy_responder.sv
// Directed + randomized bench for pipe_phy_responder with a lane-level reference model.
module tb_pipe_phy_responder;
  import pcie_pipe_pkg::*;

  localparam int L    = 16;
  localparam int W    = 32;
  localparam int KW   = W / 8;
  localparam int DL   = 8;
  localparam int PDL  = 4;
  localparam int RL   = 16;
  localparam int RSTL = 4;

  logic            CLK = 1'b0;
  logic            reset;
  logic [W*L-1:0]  TxData, RxData, far_rx_data, far_tx_data;
  logic [KW*L-1:0] TxDataK, RxDataK, far_rx_datak, far_tx_datak;
  logic [L-1:0]    TxDataValid, TxElecIdle, TxDetectRx_Loopback;
  logic [4*L-1:0]  PowerDown;
  logic [3:0]      Rate;
  logic [L-1:0]    RxDataValid, RxValid, RxElectricalIdle, PhyStatus;
  logic [3*L-1:0]  RxStatus;
  logic            far_present;
  logic [L-1:0]    far_rx_valid, far_rx_elecidle, far_tx_valid, far_tx_elecidle;

  int errors = 0;
  int checks = 0;

  pipe_phy_responder #(
    .LANESNUMBER(L), .MAXPIPEWIDTH(W), .DETECT_LATENCY(DL), .PD_LATENCY(PDL),
    .RATE_LATENCY(RL), .RESET_LATENCY(RSTL)
  ) dut (
    .CLK(CLK), .reset(reset),
    .TxData(TxData), .TxDataK(TxDataK), .TxDataValid(TxDataValid), .TxElecIdle(TxElecIdle),
    .TxDetectRx_Loopback(TxDetectRx_Loopback), .PowerDown(PowerDown), .Rate(Rate),
    .RxData(RxData), .RxDataK(RxDataK), .RxDataValid(RxDataValid), .RxValid(RxValid),
    .RxStatus(RxStatus), .RxElectricalIdle(RxElectricalIdle), .PhyStatus(PhyStatus),
    .far_present(far_present), .far_rx_data(far_rx_data), .far_rx_datak(far_rx_datak),
    .far_rx_valid(far_rx_valid), .far_rx_elecidle(far_rx_elecidle),
    .far_tx_data(far_tx_data), .far_tx_datak(far_tx_datak),
    .far_tx_valid(far_tx_valid), .far_tx_elecidle(far_tx_elecidle)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*L-1:0] rand_data();
    logic [W*L-1:0] v;
    for (int i = 0; i < L; i++) v[W*i +: W] = $urandom;
    return v;
  endfunction

  function automatic logic [KW*L-1:0] rand_k();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [4*L-1:0] all_pd(input logic [3:0] pd);
    logic [4*L-1:0] v;
    for (int i = 0; i < L; i++) v[4*i +: 4] = pd;
    return v;
  endfunction

  // Every output at its reset value
  task automatic chk_reset_vals(input string tag);
    chk({tag, ".PhyStatus"}, 512'(PhyStatus), 512'({L{1'b1}}));
    chk({tag, ".RxStatus"}, 512'(RxStatus), 512'(0));
    chk({tag, ".RxData"}, 512'(RxData), 512'(0));
    chk({tag, ".RxDataK"}, 512'(RxDataK), 512'(0));
    chk({tag, ".RxDataValid"}, 512'(RxDataValid), 512'(0));
    chk({tag, ".RxValid"}, 512'(RxValid), 512'(0));
    chk({tag, ".RxElectricalIdle"}, 512'(RxElectricalIdle), 512'({L{1'b1}}));
    chk({tag, ".far_tx_data"}, 512'(far_tx_data), 512'(0));
    chk({tag, ".far_tx_datak"}, 512'(far_tx_datak), 512'(0));
    chk({tag, ".far_tx_valid"}, 512'(far_tx_valid), 512'(0));
    chk({tag, ".far_tx_elecidle"}, 512'(far_tx_elecidle), 512'({L{1'b1}}));
  endtask

  // Command accepted at the next edge E0; PhyStatus must pulse exactly after edge E0+lat
  task automatic expect_pulse(input string tag, input int lat, input logic [3*L-1:0] exp_rxs);
    for (int k = 0; k < lat; k++) begin
      step();
      chk({tag, ".wait"}, 512'(PhyStatus), 512'(0));
    end
    step();
    chk({tag, ".pulse"}, 512'(PhyStatus), 512'({L{1'b1}}));
    chk({tag, ".rxstatus"}, 512'(RxStatus), 512'(exp_rxs));
    step();
    chk({tag, ".after"}, 512'(PhyStatus), 512'(0));
    chk({tag, ".after_rxs"}, 512'(RxStatus), 512'(0));
  endtask

  logic [3:0]      pd_choices [4];
  logic [W*L-1:0]  dmask, prev_rd;
  logic [KW*L-1:0] kmask, prev_rk;
  logic [L-1:0]    exp_v, exp_ei, exp_dv, exp_rv, prev_rv, prev_rei;
  logic [3*L-1:0]  det_code;

  initial begin
    pd_choices[0] = PD_P0; pd_choices[1] = PD_P0S; pd_choices[2] = PD_P1; pd_choices[3] = PD_P2;
    det_code = {L{RXSTAT_DETECTED}};
    reset = 1'b1;
    TxData = '0; TxDataK = '0; TxDataValid = '0; TxElecIdle = '1; TxDetectRx_Loopback = '0;
    PowerDown = all_pd(PD_P1); Rate = 4'd0; far_present = 1'b1;
    far_rx_data = rand_data(); far_rx_datak = rand_k(); far_rx_valid = '1; far_rx_elecidle = '0;

    // 1. reset values and the PhyStatus hold after release
    repeat (3) step();
    chk_reset_vals("reset");
    reset = 1'b0;
    for (int k = 1; k < RSTL; k++) begin
      step();
      chk("rst_hold", 512'(PhyStatus), 512'({L{1'b1}}));
    end
    step();
    chk("rst_release", 512'(PhyStatus), 512'(0));
    far_rx_elecidle = '1;
    step();
    chk("rx_eidle", 512'(RxElectricalIdle), 512'({L{1'b1}}));

    // 2. receiver detect with and without a far-end receiver
    TxDetectRx_Loopback = '1;
    expect_pulse("detect_present", DL, det_code);
    far_present = 1'b0;
    TxDetectRx_Loopback = '0;
    step();
    TxDetectRx_Loopback = '1;
    expect_pulse("detect_absent", DL, '0);

    // 3. Rate and PowerDown change together: rate serviced first, then the pending PowerDown
    TxDetectRx_Loopback = '0;
    step();
    PowerDown = all_pd(PD_P0);
    Rate = 4'd1;
    expect_pulse("rate_first", RL, '0);
    expect_pulse("pd_second", PDL, '0);

    // 4a. random per-lane power states with random Tx/Rx traffic
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < L; i++) PowerDown[4*i +: 4] = pd_choices[$urandom_range(0, 3)];
      TxData = rand_data(); TxDataK = rand_k();
      TxDataValid = 16'($urandom); TxElecIdle = 16'($urandom);
      far_rx_data = rand_data(); far_rx_datak = rand_k();
      far_rx_valid = 16'($urandom); far_rx_elecidle = 16'($urandom);
      step();
      dmask = '0; kmask = '0;
      for (int i = 0; i < L; i++) begin
        if (PowerDown[4*i +: 4] == PD_P0) begin
          dmask[W*i +: W] = '1;
          kmask[KW*i +: KW] = '1;
          exp_v[i]  = TxDataValid[i];
          exp_ei[i] = TxElecIdle[i];
          exp_dv[i] = far_rx_valid[i];
          exp_rv[i] = far_rx_valid[i] & ~far_rx_elecidle[i];
        end else begin
          exp_v[i]  = 1'b0;
          exp_ei[i] = 1'b1;
          exp_dv[i] = 1'b0;
          exp_rv[i] = 1'b0;
        end
      end
      chk("rnd.far_tx_data", 512'(far_tx_data & dmask), 512'(TxData & dmask));
      chk("rnd.far_tx_datak", 512'(far_tx_datak & kmask), 512'(TxDataK & kmask));
      chk("rnd.far_tx_valid", 512'(far_tx_valid), 512'(exp_v));
      chk("rnd.far_tx_elecidle", 512'(far_tx_elecidle), 512'(exp_ei));
      chk("rnd.RxData", 512'(RxData), 512'(far_rx_data));
      chk("rnd.RxDataK", 512'(RxDataK), 512'(far_rx_datak));
      chk("rnd.RxDataValid", 512'(RxDataValid), 512'(exp_dv));
      chk("rnd.RxValid", 512'(RxValid), 512'(exp_rv));
      chk("rnd.RxElectricalIdle", 512'(RxElectricalIdle), 512'(far_rx_elecidle));
    end

    // 4b. all lanes P0, fixed partner pattern
    PowerDown = all_pd(PD_P0);
    repeat (40) step();
    TxDataValid = '1; TxElecIdle = '0; TxData = rand_data(); TxDataK = rand_k();
    for (int i = 0; i < L; i++) far_rx_data[W*i +: W] = 32'hA5A5A5A5;
    far_rx_datak = '0; far_rx_valid = '1; far_rx_elecidle = '0;
    step();
    chk("p0.far_tx_data", 512'(far_tx_data), 512'(TxData));
    chk("p0.far_tx_valid", 512'(far_tx_valid), 512'({L{1'b1}}));
    chk("p0.RxData", 512'(RxData), 512'(far_rx_data));
    chk("p0.RxValid", 512'(RxValid), 512'({L{1'b1}}));
    chk("p0.PhyStatus", 512'(PhyStatus), 512'(0));
    prev_rd = far_rx_data; prev_rk = far_rx_datak; prev_rv = far_rx_valid; prev_rei = far_rx_elecidle;

    // 5. loopback: partner data comes back two edges later, MAC data ignored
    TxDetectRx_Loopback = '1;
    for (int n = 0; n < 12; n++) begin
      TxData = rand_data(); TxDataK = rand_k();
      far_rx_data = rand_data(); far_rx_datak = rand_k();
      far_rx_valid = 16'($urandom); far_rx_elecidle = 16'($urandom);
      step();
      chk("lpbk.far_tx_data", 512'(far_tx_data), 512'(prev_rd));
      chk("lpbk.far_tx_datak", 512'(far_tx_datak), 512'(prev_rk));
      chk("lpbk.far_tx_valid", 512'(far_tx_valid), 512'(prev_rv));
      chk("lpbk.far_tx_elecidle", 512'(far_tx_elecidle), 512'(prev_rei));
      prev_rd = far_rx_data; prev_rk = far_rx_datak;
      prev_rv = far_rx_valid; prev_rei = far_rx_elecidle;
    end
    chk("lpbk.no_detect", 512'(PhyStatus), 512'(0));

    // 6. reset in the middle of a detect countdown
    TxDetectRx_Loopback = '0;
    PowerDown = all_pd(PD_P1);
    far_present = 1'b1;
    repeat (10) step();
    TxDetectRx_Loopback = '1;
    for (int k = 0; k < DL / 2; k++) begin
      step();
      chk("abort.wait", 512'(PhyStatus), 512'(0));
    end
    reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    step();
    reset = 1'b0;
    for (int k = 1; k < RSTL; k++) begin
      step();
      chk("abort.rst_hold", 512'(PhyStatus), 512'({L{1'b1}}));
    end
    step();
    chk("abort.rst_release", 512'(PhyStatus), 512'(0));
    for (int k = 0; k < DL + 4; k++) begin
      step();
      chk("abort.no_pulse", 512'(PhyStatus), 512'(0));
      chk("abort.no_status", 512'(RxStatus), 512'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
